// File: rtl/wb_stage.sv
// RV32I writeback: formats ALU/load/PC+4 results and holds each rd write for WRITE_HOLD clocks; optional instret counter under WB_INSTRET_EN.
// Latency: write visible one clock after accept; in_ready is low during HOLD except on its final cycle.
module wb_stage #(
    parameter int WRITE_HOLD = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_reg_write,
    input  logic [4:0]  in_rd,
    input  logic [1:0]  in_wb_sel,
    input  logic [2:0]  in_funct3,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_load_word,
    input  logic [31:0] in_pc_plus4,
    output logic        RegWrite,
    output logic [4:0]  WriteAddr,
    output logic [31:0] WriteData,
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output logic [31:0] fwd_data,
    output logic        misalign,
    output logic [63:0] instret
);

    typedef enum logic {IDLE, HOLD} state_t;

    localparam logic [3:0] LAST = 4'(WRITE_HOLD - 1);

    state_t      state, state_nxt;
    logic [3:0]  hold_cnt, hold_cnt_nxt;
    logic        accept, wr, last_cycle, misalign_nxt;
    logic [1:0]  off;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data, result;

    assign off        = in_alu_result[1:0];
    assign last_cycle = (state == HOLD) && (hold_cnt == LAST);
    assign accept     = in_valid && in_ready;
    assign wr         = accept && in_reg_write && (in_rd != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            hold_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        hold_cnt_nxt = hold_cnt;
        case (state)
            IDLE: begin
                if (wr) begin
                    state_nxt    = HOLD;
                    hold_cnt_nxt = 4'd0;
                end
            end
            HOLD: begin
                // Final hold cycle: a fresh write restarts the window with no bubble.
                if (hold_cnt == LAST) begin
                    state_nxt    = wr ? HOLD : IDLE;
                    hold_cnt_nxt = 4'd0;
                end else begin
                    hold_cnt_nxt = hold_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                hold_cnt_nxt = 4'd0;
            end
        endcase
    end

    always_comb begin
        in_ready  = rst && ((state == IDLE) || last_cycle);
        RegWrite  = (state == HOLD);
        fwd_valid = (state == HOLD);
    end

    assign fwd_rd   = WriteAddr;
    assign fwd_data = WriteData;

    always_comb begin
        ld_byte = in_load_word[{off, 3'b000} +: 8];
        ld_half = off[1] ? in_load_word[31:16] : in_load_word[15:0];
        case (in_funct3)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = in_load_word;
        endcase
        case (in_wb_sel)
            2'b01:   result = ld_data;
            2'b10:   result = in_pc_plus4;
            default: result = in_alu_result;
        endcase
    end

    always_comb begin
        misalign_nxt = 1'b0;
        if (accept && (in_wb_sel == 2'b01)) begin
            if (in_funct3[1:0] == 2'b01)
                misalign_nxt = off[0];
            else if (in_funct3 == 3'b010)
                misalign_nxt = (off != 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WriteAddr <= 5'd0;
            WriteData <= 32'd0;
            misalign  <= 1'b0;
        end else begin
            misalign <= misalign_nxt;
            if (wr) begin
                WriteAddr <= in_rd;
                WriteData <= result;
            end
        end
    end

`ifdef WB_INSTRET_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            instret <= 64'd0;
        else if (accept)
            instret <= instret + 64'd1;
    end
`else
    assign instret = 64'd0;
`endif

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage of the pipelined RV32I core.
- Sits between the MEM/WB boundary and the register file.
- Accepts one retiring instruction per handshake, selects and formats the result (ALU, load, PC+4), and drives the register-file write port (RegWrite/WriteAddr/WriteData).
- Holds each write stable for WRITE_HOLD clocks so the half-rate write window of the register file always lands inside it.
- Exposes the pending write as a forwarding source for decode.

Parameters:
- WRITE_HOLD, 2, clocks each register write is held asserted; legal range 1..15.

Ports:
- clk  input  1  core clock
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  MEM stage presents a retiring instruction
- in_ready  output  1  stage can accept this cycle
- in_reg_write  input  1  instruction writes rd
- in_rd  input  5  destination register
- in_wb_sel  input  2  00 ALU, 01 load, 10 PC+4, 11 ALU (reserved)
- in_funct3  input  3  load width/sign
- in_alu_result  input  32  ALU result; also the load address
- in_load_word  input  32  raw aligned word from data memory
- in_pc_plus4  input  32  PC+4 for JAL/JALR
- RegWrite  output  1  register-file write enable
- WriteAddr  output  5  register-file write address
- WriteData  output  32  register-file write data
- fwd_valid  output  1  pending/active write visible to decode
- fwd_rd  output  5  forwarded register
- fwd_data  output  32  forwarded value
- misalign  output  1  one-cycle pulse: accepted load was misaligned
- instret  output  64  retired-instruction count (see Optional Feature)

Behaviour:
- Reset (rst low, async):
  - state=IDLE, hold_cnt=0.
  - RegWrite, WriteAddr, WriteData, fwd_*, misalign and instret all 0.
  - in_ready=0 while rst is low.
  - A write in progress is abandoned immediately.
- States:
  - IDLE: in_ready=1.
  - HOLD: RegWrite=1, hold_cnt counts 0..WRITE_HOLD-1.
- Accept = in_valid && in_ready, sampled at posedge clk.
- On accept with in_reg_write=1 and in_rd!=0:
  - Result is registered into WriteData/WriteAddr.
  - Next state is HOLD with hold_cnt=0.
  - RegWrite is asserted from the cycle after accept for exactly WRITE_HOLD cycles.
- On accept with in_reg_write=0 or in_rd=0: no RegWrite, stay IDLE; the instruction still counts as retired.
- HOLD:
  - in_ready=0 except on the final hold cycle (hold_cnt==WRITE_HOLD-1), where in_ready=1.
  - A new accept on that final cycle goes directly to HOLD (hold_cnt=0) with new data, giving back-to-back writes with no bubble.
  - Otherwise the block returns to IDLE and RegWrite drops.
- WriteAddr/WriteData stay stable for the entire HOLD period. They keep their last value in IDLE; RegWrite=0 there.
- Result select:
  - wb_sel 00/11 -> in_alu_result.
  - wb_sel 10 -> in_pc_plus4.
  - wb_sel 01 -> load formatting, with off = in_alu_result[1:0]:
    - LB 000: byte[off], sign-extended.
    - LBU 100: byte[off], zero-extended.
    - LH 001 / LHU 101: halfword selected by off[1]; sign- or zero-extended respectively.
    - LW 010 and undefined codes 011/110/111: full word.
- Misalignment:
  - misalign pulses high for one cycle, the cycle after accept, when:
    - LH/LHU is accepted with off[0]=1, or
    - LW is accepted with off!=0.
  - The data is still written, as formatted above, with bit 0 (or bits 1:0) ignored.
- Forwarding: fwd_valid = (state==HOLD); fwd_rd=WriteAddr; fwd_data=WriteData.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - instret is a 64-bit counter that increments by 1 on every accept, including no-write instructions.
  - It wraps from all-ones to 0.
  - It is cleared by reset.
- Undefined: instret is tied to 64'd0 and no counter flops exist.

Test Plan:
- Reset mid-HOLD: accept rd=5 data 0x1234; assert rst low 1 cycle later -> RegWrite=0 immediately, all outputs 0, in_ready=0; after release in_ready=1, state IDLE.
- ALU write, WRITE_HOLD=2: accept rd=3, wb_sel=00, alu=0xDEADBEEF -> RegWrite high for exactly 2 cycles starting the cycle after accept, WriteAddr=3, WriteData=0xDEADBEEF, fwd_valid high for the same 2 cycles.
- Loads on in_load_word=0x80FF7F01:
  - LB off=2 -> 0xFFFFFFFF.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=0 -> 0x00007F01.
  - LW -> 0x80FF7F01.
- x0 and no-write: accept rd=0 reg_write=1, then rd=7 reg_write=0 -> RegWrite never asserts, in_ready stays 1; with WB_INSTRET_EN, instret=2.
- Back-to-back: in_valid held high with rd=1, 2, 3 -> each accepted on the final HOLD cycle; RegWrite continuously high for 6 cycles; WriteAddr 1,1,2,2,3,3; with WB_INSTRET_EN, instret=3.
- Misaligned LH at alu_result=0x1001 -> misalign pulses 1 cycle, WriteData = sign-extended lower halfword; JAL with pc_plus4=0x00000104, rd=1 -> WriteData=0x00000104.
